alu_exec_pipe: RTL and testbench

//  Parametrised, pipelined RV32I/RV64I integer execute unit for OP (0110011) and OP-IMM (0010011) instructions.

---
 rtl/alu_exec_pipe.sv | 131 +++++++++++++
 tb/tb_alu_exec_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_pipe.sv
// Pipelined RV32I/RV64I integer execute unit for OP and OP-IMM instructions.
// The result is computed at accept; the remaining stages carry {valid, result, rd} under valid/ready flow control.
module alu_exec_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned RD_W   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_op_a,
    input  logic [XLEN-1:0] in_op_b,
    input  logic [11:0]     in_imm,
    input  logic            in_use_imm,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            busy
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [XLEN-1:0]        op_b_c;
    logic [SHW-1:0]         shamt_c;
    logic signed [XLEN-1:0] sra_c;
    logic                   lt_s_c;
    logic                   lt_u_c;
    logic [XLEN-1:0]        alu_c;
    logic [XLEN-1:0]        res_c;

    logic [STAGES-1:0]      v_q, v_d;
    logic [XLEN-1:0]        res_q [STAGES];
    logic [XLEN-1:0]        res_d [STAGES];
    logic [RD_W-1:0]        rd_q  [STAGES];
    logic [RD_W-1:0]        rd_d  [STAGES];
    logic [STAGES-1:0]      adv_c;
    logic [STAGES-1:0]      ld_c;
    logic                   nxt_ld_c;
    logic                   accept_c;

    // Operand select and ALU; writes to x0 are zeroed but still flow down the pipe
    always_comb begin
        op_b_c  = in_use_imm ? {{(XLEN-12){in_imm[11]}}, in_imm} : in_op_b;
        shamt_c = op_b_c[SHW-1:0];
        sra_c   = $signed(in_op_a) >>> shamt_c;
        lt_s_c  = $signed(in_op_a) < $signed(op_b_c);
        lt_u_c  = in_op_a < op_b_c;
        alu_c   = '0;
        case (in_funct3)
            3'b000: begin
                if (!in_use_imm && in_funct7b5) alu_c = in_op_a - op_b_c;
                else                            alu_c = in_op_a + op_b_c;
            end
            3'b001: alu_c = in_op_a << shamt_c;
            3'b010: alu_c = {{(XLEN-1){1'b0}}, lt_s_c};
            3'b011: alu_c = {{(XLEN-1){1'b0}}, lt_u_c};
            3'b100: alu_c = in_op_a ^ op_b_c;
            3'b101: begin
                if (in_funct7b5) alu_c = XLEN'(sra_c);
                else             alu_c = in_op_a >> shamt_c;
            end
            3'b110: alu_c = in_op_a | op_b_c;
            3'b111: alu_c = in_op_a & op_b_c;
            default: alu_c = '0;
        endcase
        res_c = (in_rd == '0) ? '0 : alu_c;
    end

    // Ready chain from the output back to stage 0, then next-state for every stage
    always_comb begin
        adv_c    = '0;
        ld_c     = '0;
        nxt_ld_c = out_ready;
        v_d      = v_q;
        res_d    = res_q;
        rd_d     = rd_q;
        for (int unsigned i = 0; i < STAGES; i++) begin
            adv_c[STAGES-1-i] = v_q[STAGES-1-i] && nxt_ld_c;
            ld_c[STAGES-1-i]  = !v_q[STAGES-1-i] || adv_c[STAGES-1-i];
            nxt_ld_c          = ld_c[STAGES-1-i];
        end
        in_ready = !flush && ld_c[0];
        accept_c = in_valid && in_ready;

        if (ld_c[0]) begin
            v_d[0] = accept_c;
            if (accept_c) begin
                res_d[0] = res_c;
                rd_d[0]  = in_rd;
            end
        end
        for (int unsigned k = 1; k < STAGES; k++) begin
            if (ld_c[k]) begin
                v_d[k] = adv_c[k-1];
                if (adv_c[k-1]) begin
                    res_d[k] = res_q[k-1];
                    rd_d[k]  = rd_q[k-1];
                end
            end
        end
        if (flush) v_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                rd_q[k]  <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                res_q[k] <= res_d[k];
                rd_q[k]  <= rd_d[k];
            end
        end
    end

    assign out_valid  = v_q[STAGES-1];
    assign out_result = res_q[STAGES-1];
    assign out_rd     = rd_q[STAGES-1];
    assign busy       = |v_q;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe (XLEN=32, STAGES=2): vector table plus stall, flush and reset sequences.
module tb_alu_exec_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_op_a = '0;
    logic [31:0] in_op_b = '0;
    logic [11:0] in_imm = '0;
    logic        in_use_imm = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7b5 = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    alu_exec_pipe #(.XLEN(32), .STAGES(2), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op_a(in_op_a), .in_op_b(in_op_b), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [11:0] imm;
        logic        use_imm;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [11:0] imm,
                            input logic ui, input logic [2:0] f3, input logic f7, input logic [4:0] rd);
        in_valid    = 1'b1;
        in_op_a     = a;
        in_op_b     = b;
        in_imm      = imm;
        in_use_imm  = ui;
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_rd       = rd;
    endtask

    initial begin
        int idx_in, idx_out, cyc, seen;
        logic stalled;
        logic [31:0] held_res;
        logic [4:0]  held_rd;

        //          a             b             imm      ui    f3      f7    rd     expected
        vecs[0]  = '{32'h5,        32'h0,        12'hFFF, 1'b1, 3'b000, 1'b0, 5'd3,  32'h4};        // ADDI
        vecs[1]  = '{32'hFFFFFFFF, 32'h1,        12'h000, 1'b0, 3'b010, 1'b0, 5'd4,  32'h1};        // SLT
        vecs[2]  = '{32'hFFFFFFFF, 32'h1,        12'h000, 1'b0, 3'b011, 1'b0, 5'd5,  32'h0};        // SLTU
        vecs[3]  = '{32'h5,        32'h0,        12'hFFF, 1'b1, 3'b011, 1'b0, 5'd6,  32'h1};        // SLTIU
        vecs[4]  = '{32'h80000000, 32'h0,        12'h401, 1'b1, 3'b101, 1'b1, 5'd8,  32'hC0000000}; // SRAI
        vecs[5]  = '{32'h80000000, 32'h21,       12'h000, 1'b0, 3'b101, 1'b0, 5'd9,  32'h40000000}; // SRL masked
        vecs[6]  = '{32'h3,        32'h5,        12'h000, 1'b0, 3'b000, 1'b1, 5'd0,  32'h0};        // SUB to x0
        vecs[7]  = '{32'h3,        32'h5,        12'h000, 1'b0, 3'b000, 1'b1, 5'd7,  32'hFFFFFFFE}; // SUB
        vecs[8]  = '{32'hA,        32'h0,        12'h005, 1'b1, 3'b000, 1'b1, 5'd10, 32'hF};        // ADDI ignores b30
        vecs[9]  = '{32'h1,        32'h3F,       12'h000, 1'b0, 3'b001, 1'b0, 5'd11, 32'h80000000}; // SLL masked
        vecs[10] = '{32'hF0F0,     32'hFF00,     12'h000, 1'b0, 3'b100, 1'b0, 5'd12, 32'h0FF0};     // XOR
        vecs[11] = '{32'hF0F0,     32'hFF00,     12'h000, 1'b0, 3'b110, 1'b0, 5'd13, 32'hFFF0};     // OR
        vecs[12] = '{32'hF0F0,     32'hFF00,     12'h000, 1'b0, 3'b111, 1'b0, 5'd14, 32'hF000};     // AND
        vecs[13] = '{32'h80000000, 32'h0,        12'h7FF, 1'b1, 3'b010, 1'b0, 5'd15, 32'h1};        // SLTI
        vecs[14] = '{32'hFFFFFF00, 32'h4,        12'h000, 1'b0, 3'b101, 1'b1, 5'd16, 32'hFFFFFFF0}; // SRA

        // Reset state
        #2;
        check("rst out_valid", 64'(out_valid), 64'h0);
        check("rst busy", 64'(busy), 64'h0);
        check("rst out_result", 64'(out_result), 64'h0);
        check("rst out_rd", 64'(out_rd), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst in_ready", 64'(in_ready), 64'h1);

        // Single ops: latency STAGES=2, then result and rd
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive_op(vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].use_imm, vecs[i].f3, vecs[i].f7, vecs[i].rd);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d early valid", i), 64'(out_valid), 64'h0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'h1);
            check($sformatf("v%0d result", i), 64'(out_result), 64'(vecs[i].exp));
            check($sformatf("v%0d rd", i), 64'(out_rd), 64'(vecs[i].rd));
        end
        @(negedge clk);
        @(negedge clk);
        check("drain busy", 64'(busy), 64'h0);

        // Stream 8 ADDs with out_ready low for cycles 3..5
        idx_in = 0; idx_out = 0; stalled = 1'b0; held_res = '0; held_rd = '0;
        for (cyc = 0; cyc < 40 && idx_out < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (idx_in < 8) drive_op(32'(idx_in), 32'd100, 12'h0, 1'b0, 3'b000, 1'b0, 5'(idx_in + 1));
            else            in_valid = 1'b0;
            #1;
            if (stalled) begin
                check($sformatf("stall hold res c%0d", cyc), 64'(out_result), 64'(held_res));
                check($sformatf("stall hold rd c%0d", cyc), 64'(out_rd), 64'(held_rd));
            end
            stalled  = out_valid && !out_ready;
            held_res = out_result;
            held_rd  = out_rd;
            if (out_valid && out_ready) begin
                check($sformatf("stream res %0d", idx_out), 64'(out_result), 64'(idx_out + 100));
                check($sformatf("stream rd %0d", idx_out), 64'(out_rd), 64'(idx_out + 1));
                idx_out++;
            end
            if (in_valid && in_ready) idx_in++;
            @(posedge clk);
        end
        check("stream count", 64'(idx_out), 64'd8);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("stream no extra", 64'(out_valid), 64'h0);

        // Flush with two ops held in flight and a third presented
        out_ready = 1'b0;
        drive_op(32'd1, 32'd2, 12'h0, 1'b0, 3'b000, 1'b0, 5'd1);
        @(negedge clk);
        drive_op(32'd3, 32'd4, 12'h0, 1'b0, 3'b000, 1'b0, 5'd2);
        @(negedge clk);
        drive_op(32'd5, 32'd6, 12'h0, 1'b0, 3'b000, 1'b0, 5'd3);
        flush = 1'b1;
        #1;
        check("flush busy before", 64'(busy), 64'h1);
        check("flush in_ready", 64'(in_ready), 64'h0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("flush busy after", 64'(busy), 64'h0);
        check("flush out_valid", 64'(out_valid), 64'h0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush no late out", 64'(seen), 64'h0);

        // Reset pulsed mid-stream
        drive_op(32'd7, 32'd8, 12'h0, 1'b0, 3'b000, 1'b0, 5'd4);
        @(negedge clk);
        drive_op(32'd9, 32'd1, 12'h0, 1'b0, 3'b000, 1'b0, 5'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst mid out_valid", 64'(out_valid), 64'h0);
        check("rst mid busy", 64'(busy), 64'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst no late out", 64'(seen), 64'h0);
        check("rst idle in_ready", 64'(in_ready), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
